cas_player: RTL and testbench

- Plays a downloaded .CAS image back as a TRS-80 500-baud cassette pulse stream.
- Sits between the download/buffer path and the ht1080z cassette input; its output is muxed with the external tape input.
- Fetches image bytes one at a time through a request/acknowledge port and serialises each byte MSB first.
- Each bit cell carries a clock pulse; a 1 bit adds a second data pulse at mid-cell.
- Playback is gated by the machine's cassette motor signal.

---
 rtl/cas_player.sv | 165 ++++++++++++++++
 tb/tb_cas_player.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cas_player.sv
// TRS-80 500-baud cassette player: fetches .CAS bytes over a req/ack port and
// emits one clock pulse per bit cell plus a mid-cell data pulse for each 1 bit.
module cas_player #(
  parameter int CELL_CYCLES  = 84000,
  parameter int PULSE_CYCLES = 5376,
  parameter int ADDR_W       = 16
) (
  input  logic              clk42m,
  input  logic              reset_n,
  input  logic              rewind,
  input  logic [ADDR_W-1:0] tape_len,
  input  logic              motor,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [7:0]        rd_data,
  output logic              cass_out,
  output logic              active,
  output logic              done
);
  localparam int CW = $clog2(CELL_CYCLES);
  // Each boundary is matched one count early so the registered cass_out
  // changes exactly as the counter reaches the boundary value.
  localparam logic [CW-1:0] PULSE_END = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] MID_PRE   = CW'(CELL_CYCLES / 2 - 1);
  localparam logic [CW-1:0] DATA_END  = CW'(CELL_CYCLES / 2 + PULSE_CYCLES - 1);
  localparam logic [CW-1:0] CELL_END  = CW'(CELL_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, CLK_HI, WAIT_MID, DATA_HI, WAIT_END, FINISHED
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        sh_q, sh_d;
  logic [ADDR_W-1:0] len_q, len_d, addr_q, addr_d;
  logic              req_q, req_d, cass_q, cass_d, done_q, done_d;
  logic [ADDR_W:0]   addr_nx;
  logic [CW-1:0]     cnt_inc;

  // One extra bit so rd_addr+1 can never wrap before the compare.
  assign addr_nx = {1'b0, addr_q} + {{ADDR_W{1'b0}}, 1'b1};
  assign cnt_inc = cnt_q + CW'(1);

  always_ff @(posedge clk42m) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd7;
      sh_q    <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      cass_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      cass_q  <= cass_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    len_d   = len_q;
    addr_d  = addr_q;
    req_d   = req_q;
    cass_d  = cass_q;
    done_d  = done_q;
    if (rewind) begin
      len_d  = tape_len;
      addr_d = '0;
      req_d  = 1'b0;
      cass_d = 1'b0;
      cnt_d  = '0;
      if (tape_len == '0) begin
        state_d = FINISHED;
        done_d  = 1'b1;
      end else begin
        state_d = FETCH;
        done_d  = 1'b0;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (req_q && rd_ack) begin
            sh_d    = rd_data;
            bit_d   = 3'd7;
            cnt_d   = '0;
            req_d   = 1'b0;
            cass_d  = 1'b1;
            state_d = CLK_HI;
          end else begin
            // once raised, the request stays up until acknowledged
            req_d = req_q | motor;
          end
        end
        CLK_HI: if (motor) begin
          cnt_d = cnt_inc;
          if (cnt_q == PULSE_END) begin
            cass_d  = 1'b0;
            state_d = WAIT_MID;
          end
        end
        WAIT_MID: if (motor) begin
          cnt_d = cnt_inc;
          if (cnt_q == MID_PRE) begin
            if (sh_q[bit_q]) begin
              cass_d  = 1'b1;
              state_d = DATA_HI;
            end else begin
              state_d = WAIT_END;
            end
          end
        end
        DATA_HI: if (motor) begin
          cnt_d = cnt_inc;
          if (cnt_q == DATA_END) begin
            cass_d  = 1'b0;
            state_d = WAIT_END;
          end
        end
        WAIT_END: if (motor) begin
          cnt_d = cnt_inc;
          if (cnt_q == CELL_END) begin
            cnt_d = '0;
            if (bit_q != 3'd0) begin
              bit_d   = bit_q - 3'd1;
              cass_d  = 1'b1;
              state_d = CLK_HI;
            end else if (addr_nx < {1'b0, len_q}) begin
              addr_d  = addr_nx[ADDR_W-1:0];
              state_d = FETCH;
            end else begin
              state_d = FINISHED;
              done_d  = 1'b1;
            end
          end
        end
        FINISHED: begin
          cass_d = 1'b0;
          done_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rd_req   = req_q;
  assign rd_addr  = addr_q;
  assign cass_out = cass_q;
  assign done     = done_q;
  assign active   = motor && (state_q != IDLE) && (state_q != FINISHED);

endmodule

// File: tb/tb_cas_player.sv
// Directed bench for cas_player with CELL_CYCLES=100, PULSE_CYCLES=10 and a
// byte responder that acknowledges two cycles after each request.
module tb_cas_player;
  localparam int CELL = 100;
  localparam int PULSE = 10;
  localparam int AW = 16;
  localparam int ACK_LAT = 2;

  logic          clk42m = 1'b0;
  logic          reset_n, rewind, motor, rd_ack, rd_req, cass_out, active, done;
  logic [AW-1:0] tape_len, rd_addr;
  logic [7:0]    rd_data;

  logic [7:0]    mem [0:3];
  logic          resp_en;
  int            hs_cnt, rise_cnt, nchk, nerr;
  logic [AW-1:0] hs_addr[$];
  int            rise_at_ack[$];

  cas_player #(.CELL_CYCLES(CELL), .PULSE_CYCLES(PULSE), .ADDR_W(AW)) dut (
    .clk42m(clk42m), .reset_n(reset_n), .rewind(rewind), .tape_len(tape_len),
    .motor(motor), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_data(rd_data), .cass_out(cass_out), .active(active), .done(done)
  );

  always #5 clk42m = ~clk42m;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
    $fatal(1);
  end

  // byte responder: ack ACK_LAT cycles after req is seen high
  initial begin
    int wc;
    wc = 0;
    rd_ack = 1'b0;
    rd_data = 8'h00;
    forever begin
      @(negedge clk42m);
      if (rd_ack) rd_ack = 1'b0;
      else if (rd_req && resp_en) begin
        wc++;
        if (wc == ACK_LAT) begin
          rd_ack = 1'b1;
          rd_data = mem[rd_addr[1:0]];
          hs_addr.push_back(rd_addr);
          rise_at_ack.push_back(rise_cnt);
          hs_cnt++;
          wc = 0;
        end
      end else wc = 0;
    end
  end

  // rising-edge counter on cass_out
  initial begin
    logic prev;
    prev = 1'b0;
    rise_cnt = 0;
    forever begin
      @(negedge clk42m);
      if (cass_out && !prev) rise_cnt++;
      prev = cass_out;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk42m);
    #1;
  endtask

  task automatic do_rewind(input logic [AW-1:0] len);
    rewind = 1'b1;
    tape_len = len;
    tick();
    rewind = 1'b0;
  endtask

  task automatic wait_ack(input string tag);
    int h0;
    bit got;
    h0 = hs_cnt;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      tick();
      if (hs_cnt != h0) got = 1'b1;
    end
    if (!got) check({tag, "_ack_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input string tag, input int limit);
    for (int i = 0; i < limit && !done; i++) tick();
    check({tag, "_done"}, done, 1);
  endtask

  function automatic logic [127:0] cell_pat(input logic b);
    logic [127:0] p;
    p = '0;
    for (int k = 0; k < CELL; k++) p[k] = (k < PULSE) || (b && k >= 50 && k < 60);
    return p;
  endfunction

  initial begin
    logic [7:0]   pat;
    logic [127:0] obs;
    logic         bad, bad2, done_early;
    int           h0;
    nchk = 0; nerr = 0; hs_cnt = 0;
    resp_en = 1'b1;
    reset_n = 1'b0; rewind = 1'b0; tape_len = '0; motor = 1'b1;
    mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;
    tick(); tick();
    check("rst_req", rd_req, 0);
    check("rst_addr", rd_addr, 0);
    check("rst_cass", cass_out, 0);
    check("rst_active", active, 0);
    check("rst_done", done, 0);
    reset_n = 1'b1;
    tick();
    check("idle_active", active, 0);

    // 0xA5 single byte, cell-exact pulse pattern
    pat = 8'hA5;
    mem[0] = pat;
    do_rewind(1);
    check("a5_fetch_active", active, 1);
    wait_ack("a5");
    done_early = 1'b0;
    for (int c = 0; c < 8; c++) begin
      obs = '0;
      for (int k = 0; k < CELL; k++) begin
        tick();
        obs[k] = cass_out;
        done_early = done_early | done;
      end
      check($sformatf("a5_cell%0d", c), obs, cell_pat(pat[7-c]));
    end
    check("a5_done_early", done_early, 0);
    tick();
    check("a5_done", done, 1);
    check("a5_fin_active", active, 0);
    check("a5_fin_cass", cass_out, 0);

    // three bytes: address order, handshakes, pulses per byte
    mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'h80;
    hs_addr.delete(); rise_at_ack.delete();
    h0 = hs_cnt;
    do_rewind(3);
    wait_done("m3", 4000);
    check("m3_hs", hs_cnt - h0, 3);
    check("m3_addr0", hs_addr.size() > 0 ? hs_addr[0] : 16'hFFFF, 0);
    check("m3_addr1", hs_addr.size() > 1 ? hs_addr[1] : 16'hFFFF, 1);
    check("m3_addr2", hs_addr.size() > 2 ? hs_addr[2] : 16'hFFFF, 2);
    if (rise_at_ack.size() == 3) begin
      check("m3_pulses0", rise_at_ack[1] - rise_at_ack[0], 8);
      check("m3_pulses1", rise_at_ack[2] - rise_at_ack[1], 16);
      check("m3_pulses2", rise_cnt - rise_at_ack[2], 9);
    end else check("m3_ack_log", rise_at_ack.size(), 3);

    // motor pause at cell 3 offset 55 for 40 cycles
    mem[0] = 8'hFF;
    do_rewind(1);
    wait_ack("mot");
    bad = 1'b0; bad2 = 1'b0;
    for (int s = 0; s <= 840; s++) begin
      tick();
      if (s == 355) begin
        check("mot_pre_cass", cass_out, 1);
        motor = 1'b0;
      end
      if (s >= 356 && s <= 395) begin
        bad = bad | (cass_out !== 1'b1);
        bad2 = bad2 | (active !== 1'b0);
      end
      if (s == 395) motor = 1'b1;
      if (s == 399) check("mot_off59", cass_out, 1);
      if (s == 400) check("mot_off60", cass_out, 0);
      if (s == 839) check("mot_done_early", done, 0);
      if (s == 840) check("mot_done", done, 1);
    end
    check("mot_hold_cass", bad, 0);
    check("mot_inactive", bad2, 0);

    // rewind in DATA_HI of bit 4; old byte must not resume
    mem[0] = 8'hFF; mem[1] = 8'h3C;
    do_rewind(1);
    wait_ack("rw");
    for (int s = 0; s <= 355; s++) tick();
    check("rw_datahi", cass_out, 1);
    mem[0] = 8'h00;
    hs_addr.delete();
    do_rewind(2);
    check("rw_cass", cass_out, 0);
    check("rw_done", done, 0);
    check("rw_addr", rd_addr, 0);
    tick();
    check("rw_req", rd_req, 1);
    wait_ack("rw2");
    for (int s = 0; s <= 55; s++) begin
      tick();
      if (s == 5) check("rw_clk", cass_out, 1);
      if (s == 55) check("rw_nodata", cass_out, 0);
    end
    wait_done("rw", 2500);
    check("rw_hs", hs_addr.size(), 2);
    check("rw_addr_a", hs_addr.size() > 0 ? hs_addr[0] : 16'hFFFF, 0);
    check("rw_addr_b", hs_addr.size() > 1 ? hs_addr[1] : 16'hFFFF, 1);

    // zero-length tape
    h0 = hs_cnt;
    do_rewind(0);
    check("z_done", done, 1);
    check("z_active", active, 0);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bad = bad | rd_req;
      tick();
    end
    check("z_noreq", bad, 0);
    check("z_hs", hs_cnt - h0, 0);

    // reset while a fetch is pending
    resp_en = 1'b0;
    do_rewind(1);
    for (int i = 0; i < 5 && !rd_req; i++) tick();
    check("r_req_up", rd_req, 1);
    reset_n = 1'b0;
    tick();
    check("r_req", rd_req, 0);
    check("r_cass", cass_out, 0);
    check("r_active", active, 0);
    check("r_done", done, 0);
    reset_n = 1'b1;
    resp_en = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      bad = bad | rd_req | active;
    end
    check("r_idle", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
